// File: rtl/mlp_pkg.sv
// Shared definitions for the MLP layer sequencer: FSM state encoding and default sizes.
package mlp_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    L1_RUN   = 3'd1,
    L1_WAIT  = 3'd2,
    SIG_WAIT = 3'd3,
    L2_RUN   = 3'd4,
    L2_WAIT  = 3'd5,
    FIN      = 3'd6
  } seq_state_e;

  localparam int IN_LEN_D = 784;
  localparam int L1_N_D   = 200;
  localparam int L2_N_D   = 10;
  localparam int CH_D     = 10;

endpackage

// File: rtl/seq_counter.sv
// Bounded up-counter: clear has priority, counting stops at MAX (no wrap), last flags q == MAX.
module seq_counter #(
  parameter int W   = 4,
  parameter int MAX = 9
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q,
  output logic         last
);

  assign last = (q == W'(MAX));

  always_ff @(posedge clk) begin
    if (srst || clr) begin
      q <= '0;
    end else if (en && !last) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/mlp_layer_sequencer.sv
// Address/control sequencer for the two-layer MLP datapath.
// Optional stall counter output perf_stall is built when MLP_SEQ_PERF_EN is defined.
module mlp_layer_sequencer
  import mlp_pkg::*;
#(
  parameter  int IN_LEN = IN_LEN_D,
  parameter  int L1_N   = L1_N_D,
  parameter  int L2_N   = L2_N_D,
  parameter  int CH     = CH_D,
  localparam int AI_W   = $clog2(IN_LEN),
  localparam int A1_W   = $clog2(IN_LEN * L1_N),
  localparam int AH_W   = $clog2(L1_N),
  localparam int A2_W   = $clog2(L1_N * L2_N),
  localparam int SEL_W  = $clog2(CH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mac1_done,
  input  logic             sig_ready,
  input  logic             mac2_done,
  output logic [AI_W-1:0]  address_3,
  output logic [A1_W-1:0]  address_1,
  output logic [AH_W-1:0]  address_h,
  output logic [A2_W-1:0]  address_2,
  output logic [SEL_W-1:0] sel,
  output logic             mac1_start,
  output logic             mac2_start,
  output logic             busy,
  output logic             done
`ifdef MLP_SEQ_PERF_EN
  , output logic [31:0]    perf_stall
`endif
);

  localparam int O_W = $clog2(L2_N);

  seq_state_e      state_reg;
  logic            pend1_reg;
  logic [AH_W-1:0] n_q;
  logic [O_W-1:0]  o_q;
  logic            j_last, n_last, k_last, o_last, c_last;
  logic            start_acc, m1_go, sig_go, m2_go, fin_go;
  logic            j_clr, k_clr, o_clr, c_clr;

  // Neuron counters are only consumed through their last flags.
  logic unused_cnt;
  assign unused_cnt = &{1'b0, n_q, o_q};

  assign start_acc = (state_reg == IDLE) && start;
  assign m1_go     = (state_reg == L1_WAIT) && (mac1_done || pend1_reg);
  assign sig_go    = (state_reg == SIG_WAIT) && sig_ready;
  assign m2_go     = (state_reg == L2_WAIT) && mac2_done;
  assign fin_go    = m2_go && o_last && c_last;
  assign j_clr     = start_acc || (m1_go && !n_last);
  assign k_clr     = start_acc || sig_go || (m2_go && !fin_go);
  assign o_clr     = start_acc || sig_go || (m2_go && o_last && !c_last);
  assign c_clr     = start_acc || sig_go;

  seq_counter #(.W(AI_W), .MAX(IN_LEN - 1)) u_j (
    .clk(clk), .srst(reset), .clr(j_clr), .en(state_reg == L1_RUN),
    .q(address_3), .last(j_last));

  seq_counter #(.W(AH_W), .MAX(L1_N - 1)) u_n (
    .clk(clk), .srst(reset), .clr(start_acc), .en(m1_go),
    .q(n_q), .last(n_last));

  seq_counter #(.W(AH_W), .MAX(L1_N - 1)) u_k (
    .clk(clk), .srst(reset), .clr(k_clr), .en(state_reg == L2_RUN),
    .q(address_h), .last(k_last));

  seq_counter #(.W(O_W), .MAX(L2_N - 1)) u_o (
    .clk(clk), .srst(reset), .clr(o_clr), .en(m2_go),
    .q(o_q), .last(o_last));

  seq_counter #(.W(SEL_W), .MAX(CH - 1)) u_c (
    .clk(clk), .srst(reset), .clr(c_clr), .en(m2_go && o_last),
    .q(sel), .last(c_last));

  // Start pulses are registered one cycle ahead so they line up with the last element.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      pend1_reg  <= 1'b0;
      address_1  <= '0;
      address_2  <= '0;
      mac1_start <= 1'b0;
      mac2_start <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      mac1_start <= 1'b0;
      mac2_start <= 1'b0;
      done       <= 1'b0;
      case (state_reg)
        IDLE: if (start) begin
          busy       <= 1'b1;
          pend1_reg  <= 1'b0;
          address_1  <= '0;
          address_2  <= '0;
          mac1_start <= (IN_LEN == 1);
          state_reg  <= L1_RUN;
        end
        L1_RUN: if (j_last) begin
          pend1_reg <= mac1_done;
          state_reg <= L1_WAIT;
        end else begin
          address_1  <= address_1 + A1_W'(1);
          mac1_start <= (int'(address_3) == IN_LEN - 2);
        end
        L1_WAIT: if (m1_go) begin
          pend1_reg <= 1'b0;
          if (n_last) begin
            state_reg <= SIG_WAIT;
          end else begin
            address_1  <= address_1 + A1_W'(1);
            mac1_start <= (IN_LEN == 1);
            state_reg  <= L1_RUN;
          end
        end
        SIG_WAIT: if (sig_ready) begin
          address_2  <= '0;
          mac2_start <= (L1_N == 1);
          state_reg  <= L2_RUN;
        end
        L2_RUN: if (k_last) begin
          state_reg <= L2_WAIT;
        end else begin
          address_2  <= address_2 + A2_W'(1);
          mac2_start <= (int'(address_h) == L1_N - 2);
        end
        L2_WAIT: if (m2_go) begin
          if (fin_go) begin
            done      <= 1'b1;
            busy      <= 1'b0;
            state_reg <= FIN;
          end else begin
            address_2  <= o_last ? '0 : address_2 + A2_W'(1);
            mac2_start <= (L1_N == 1);
            state_reg  <= L2_RUN;
          end
        end
        FIN:     state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef MLP_SEQ_PERF_EN
  always_ff @(posedge clk) begin
    if (reset || start_acc) begin
      perf_stall <= '0;
    end else if ((state_reg == L1_WAIT || state_reg == SIG_WAIT || state_reg == L2_WAIT)
                 && perf_stall != '1) begin
      perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// Scoreboard bench for mlp_layer_sequencer in a small configuration (4/3/2/2).
module tb_mlp_layer_sequencer;

  localparam int IN_LEN = 4;
  localparam int L1_N   = 3;
  localparam int L2_N   = 2;
  localparam int CH     = 2;
  localparam int LAT    = L1_N * (IN_LEN + 1) + 1 + CH * L2_N * (L1_N + 1) + 1;

  logic clk = 1'b0;
  logic reset = 1'b1, start = 1'b0, mac1_done = 1'b1, sig_ready = 1'b1, mac2_done = 1'b1;
  logic [1:0] address_3;
  logic [3:0] address_1;
  logic [1:0] address_h;
  logic [2:0] address_2;
  logic [0:0] sel;
  logic mac1_start, mac2_start, busy, done;
`ifdef MLP_SEQ_PERF_EN
  logic [31:0] perf_stall;
`endif

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mlp_layer_sequencer #(.IN_LEN(IN_LEN), .L1_N(L1_N), .L2_N(L2_N), .CH(CH)) dut (
    .clk(clk), .reset(reset), .start(start), .mac1_done(mac1_done),
    .sig_ready(sig_ready), .mac2_done(mac2_done), .address_3(address_3),
    .address_1(address_1), .address_h(address_h), .address_2(address_2),
    .sel(sel), .mac1_start(mac1_start), .mac2_start(mac2_start),
    .busy(busy), .done(done)
`ifdef MLP_SEQ_PERF_EN
    , .perf_stall(perf_stall)
`endif
  );

  // Scoreboard queues: pulses and address change sequences.
  int q_m1_a1[$], q_m1_a3[$], q_m2_sel[$], q_m2_a2[$], q_m2_ah[$];
  int q_a1[$], q_a2[$], q_sel[$];
  int prev_a1, prev_a2, prev_sel, ev0, ev1, ev2;
  bit mon_en = 0;
  bit m1_delay = 0;
  int m1_cnt = 0;

  // Delayed mac1_done responder: pulse on the 5th cycle after mac1_start.
  always @(posedge clk) begin
    #1;
    if (m1_delay) begin
      mac1_done = 1'b0;
      if (m1_cnt != 0) begin
        m1_cnt--;
        if (m1_cnt == 0) mac1_done = 1'b1;
      end
      if (mac1_start === 1'b1) m1_cnt = 5;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (mac1_start === 1'b1) begin
        n_checks++;
        if (q_m1_a1.size() == 0) begin
          n_fail++;
          $display("FAIL mac1_pulse_extra: pulse at address_1=%0d, required none", address_1);
        end else begin
          ev0 = q_m1_a1.pop_front(); ev1 = q_m1_a3.pop_front();
          if (int'(address_1) !== ev0 || int'(address_3) !== ev1) begin
            n_fail++;
            $display("FAIL mac1_pulse: address_1=%0d address_3=%0d, required %0d %0d",
                     address_1, address_3, ev0, ev1);
          end else $display("mac1_start address_1=%0d address_3=%0d", address_1, address_3);
        end
      end
      if (mac2_start === 1'b1) begin
        n_checks++;
        if (q_m2_a2.size() == 0) begin
          n_fail++;
          $display("FAIL mac2_pulse_extra: pulse at address_2=%0d, required none", address_2);
        end else begin
          ev0 = q_m2_sel.pop_front(); ev1 = q_m2_a2.pop_front(); ev2 = q_m2_ah.pop_front();
          if (int'(sel) !== ev0 || int'(address_2) !== ev1 || int'(address_h) !== ev2) begin
            n_fail++;
            $display("FAIL mac2_pulse: sel=%0d address_2=%0d address_h=%0d, required %0d %0d %0d",
                     sel, address_2, address_h, ev0, ev1, ev2);
          end else $display("mac2_start sel=%0d address_2=%0d address_h=%0d", sel, address_2, address_h);
        end
      end
      if (int'(address_1) !== prev_a1) begin
        n_checks++;
        ev0 = (q_a1.size() != 0) ? q_a1.pop_front() : -1;
        if (int'(address_1) !== ev0) begin
          n_fail++;
          $display("FAIL address_1_seq: got %0d, required %0d", address_1, ev0);
        end
        prev_a1 = int'(address_1);
      end
      if (int'(address_2) !== prev_a2) begin
        n_checks++;
        ev0 = (q_a2.size() != 0) ? q_a2.pop_front() : -1;
        if (int'(address_2) !== ev0) begin
          n_fail++;
          $display("FAIL address_2_seq: got %0d, required %0d", address_2, ev0);
        end
        prev_a2 = int'(address_2);
      end
      if (int'(sel) !== prev_sel) begin
        n_checks++;
        ev0 = (q_sel.size() != 0) ? q_sel.pop_front() : -1;
        if (int'(sel) !== ev0) begin
          n_fail++;
          $display("FAIL sel_seq: got %0d, required %0d", sel, ev0);
        end
        prev_sel = int'(sel);
      end
    end
  end

  task automatic do_reset();
    mon_en = 0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Reference model of one full pass, starting from all-zero outputs.
  task automatic load_model();
    int pv;
    q_m1_a1.delete(); q_m1_a3.delete(); q_m2_sel.delete(); q_m2_a2.delete(); q_m2_ah.delete();
    q_a1.delete(); q_a2.delete(); q_sel.delete();
    for (int n = 0; n < L1_N; n++) begin
      q_m1_a1.push_back(n * IN_LEN + IN_LEN - 1);
      q_m1_a3.push_back(IN_LEN - 1);
    end
    for (int v = 1; v < IN_LEN * L1_N; v++) q_a1.push_back(v);
    pv = 0;
    for (int c = 0; c < CH; c++) begin
      if (c != 0) q_sel.push_back(c);
      for (int o = 0; o < L2_N; o++) begin
        q_m2_sel.push_back(c);
        q_m2_a2.push_back(o * L1_N + L1_N - 1);
        q_m2_ah.push_back(L1_N - 1);
        for (int k = 0; k < L1_N; k++) begin
          if (o * L1_N + k != pv) q_a2.push_back(o * L1_N + k);
          pv = o * L1_N + k;
        end
      end
    end
    prev_a1 = 0; prev_a2 = 0; prev_sel = 0;
    mon_en = 1;
  endtask

  task automatic run_pass(input int budget, output int cyc);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < budget) begin
      @(posedge clk); #1 cyc++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({address_3, address_1, address_h, address_2, sel, mac1_start, mac2_start, busy, done} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b, required all zero",
               {address_3, address_1, address_h, address_2, sel, mac1_start, mac2_start, busy, done});
    end else $display("reset: all outputs zero");
  endtask

  task automatic test_dones_high();
    int cyc;
    do_reset();
    load_model();
    run_pass(200, cyc);
    n_checks++;
    if (cyc !== LAT) begin
      n_fail++; $display("FAIL latency_dones_high: got %0d, required %0d", cyc, LAT);
    end else $display("pass done after %0d cycles", cyc);
`ifdef MLP_SEQ_PERF_EN
    n_checks++;
    if (perf_stall !== 32'd8) begin
      n_fail++; $display("FAIL perf_dones_high: got %0d, required 8", perf_stall);
    end
`endif
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL done_width: done=%b busy=%b, required 0 0", done, busy);
    end
    n_checks++;
    if (q_m1_a1.size() + q_m2_a2.size() + q_a1.size() + q_a2.size() + q_sel.size() != 0) begin
      n_fail++; $display("FAIL queues_dones_high: %0d entries left, required 0",
                         q_m1_a1.size() + q_m2_a2.size() + q_a1.size() + q_a2.size() + q_sel.size());
    end
    mon_en = 0;
  endtask

  task automatic test_mac1_delay();
    int cyc;
    do_reset();
    mac1_done = 1'b0; m1_cnt = 0; m1_delay = 1;
    load_model();
    run_pass(300, cyc);
    n_checks++;
    if (cyc !== LAT + 4 * L1_N) begin
      n_fail++; $display("FAIL latency_mac1_delay: got %0d, required %0d", cyc, LAT + 4 * L1_N);
    end else $display("delayed pass done after %0d cycles", cyc);
`ifdef MLP_SEQ_PERF_EN
    n_checks++;
    if (perf_stall !== 32'd20) begin
      n_fail++; $display("FAIL perf_mac1_delay: got %0d, required 20", perf_stall);
    end
`endif
    n_checks++;
    if (q_m1_a1.size() + q_m2_a2.size() + q_a1.size() != 0) begin
      n_fail++; $display("FAIL queues_mac1_delay: %0d entries left, required 0",
                         q_m1_a1.size() + q_m2_a2.size() + q_a1.size());
    end
    m1_delay = 0; mac1_done = 1'b1;
    mon_en = 0;
  endtask

  task automatic test_sig_wait();
    int cyc;
    bit bad;
    do_reset();
    sig_ready = 1'b0;
    load_model();
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc = 0;
    while (!(mac1_start === 1'b1 && address_1 == 4'd11) && cyc < 100) begin
      @(posedge clk); #1 cyc++;
    end
    @(posedge clk); #1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (mac2_start !== 1'b0 || sel !== 1'b0 || busy !== 1'b1) bad = 1;
    end
    n_checks++;
    if (bad || cyc >= 100) begin
      n_fail++; $display("FAIL sig_wait_hold: mac2_start/sel moved or busy dropped (bad=%0d cyc=%0d), required idle wait", bad, cyc);
    end
    sig_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++;
    if (address_h !== 2'd1) begin
      n_fail++; $display("FAIL l2_entry: address_h=%0d two cycles after sig_ready, required 1", address_h);
    end
    @(posedge clk); #1;
    n_checks++;
    if (mac2_start !== 1'b1) begin
      n_fail++; $display("FAIL l2_first_pulse: mac2_start=%b, required 1", mac2_start);
    end
    cyc = 0;
    while (done !== 1'b1 && cyc < 100) begin
      @(posedge clk); #1 cyc++;
    end
    n_checks++;
    if (done !== 1'b1 || q_m2_a2.size() != 0) begin
      n_fail++; $display("FAIL sig_wait_finish: done=%b left=%0d, required done and 0", done, q_m2_a2.size());
    end
    mon_en = 0;
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit bad;
    do_reset();
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc = 0;
    while (address_3 !== 2'd2 && cyc < 20) begin
      @(posedge clk); #1 cyc++;
    end
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    n_checks++;
    if ({address_3, address_1, address_h, address_2, sel, mac1_start, mac2_start, busy, done} !== '0
        || cyc >= 20) begin
      n_fail++;
      $display("FAIL reset_mid: outputs %b (cyc=%0d), required all zero",
               {address_3, address_1, address_h, address_2, sel, mac1_start, mac2_start, busy, done}, cyc);
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) bad = 1;
    end
    n_checks++;
    if (bad) begin
      n_fail++; $display("FAIL reset_mid_done: done/busy seen after abort, required 0");
    end
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n_checks++;
    if (address_1 !== 4'd0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL restart0: address_1=%0d busy=%b, required 0 1", address_1, busy);
    end
    @(posedge clk); #1;
    n_checks++;
    if (address_1 !== 4'd1) begin
      n_fail++; $display("FAIL restart1: address_1=%0d, required 1", address_1);
    end else $display("restart after mid-pass reset ok");
  endtask

  task automatic test_start_busy();
    int cyc;
    do_reset();
    load_model();
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 200) begin
      start = (cyc == 3 || cyc == 14 || cyc == 25) ? 1'b1 : 1'b0;
      @(posedge clk); #1 cyc++;
    end
    start = 1'b0;
    n_checks++;
    if (cyc !== LAT) begin
      n_fail++; $display("FAIL latency_start_busy: got %0d, required %0d", cyc, LAT);
    end else $display("pass with spurious starts done after %0d cycles", cyc);
    n_checks++;
    if (q_m1_a1.size() + q_m2_a2.size() + q_a1.size() + q_a2.size() != 0) begin
      n_fail++; $display("FAIL queues_start_busy: %0d entries left, required 0",
                         q_m1_a1.size() + q_m2_a2.size() + q_a1.size() + q_a2.size());
    end
    mon_en = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_dones_high();
    test_mac1_delay();
    test_sig_wait();
    test_reset_mid();
    test_start_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
